// File: rtl/retire_commit_if.sv
// Retire-commit bus bundle: ROB retire inputs, free-tag handshake,
// committed-store handshake, flush/redirect and error outputs.
interface retire_commit_if #(
    parameter int TAG_W = 5
);
    logic [TAG_W-1:0] Retire_rd_tag;
    logic [4:0]       Retire_rd_reg;
    logic [31:0]      Retire_data;
    logic [31:0]      Retire_pc;
    logic             Retire_branch;
    logic             Retire_branch_taken;
    logic             Retire_store_ready;
    logic             Retire_valid;
    logic             Arf_wen;
    logic [4:0]       Arf_waddr;
    logic [31:0]      Arf_wdata;
    logic [TAG_W-1:0] Tag_out;
    logic             Tag_valid;
    logic             Tag_take;
    logic [TAG_W-1:0] Store_commit_tag;
    logic             Store_commit_valid;
    logic             Store_commit_ready;
    logic             Flush;
    logic [31:0]      Redirect_pc;
    logic             Redirect_valid;
    logic             Err_overflow;

    modport master (
        output Retire_rd_tag, Retire_rd_reg, Retire_data, Retire_pc,
        output Retire_branch, Retire_branch_taken, Retire_store_ready,
        output Retire_valid, Tag_take, Store_commit_ready,
        input  Arf_wen, Arf_waddr, Arf_wdata, Tag_out, Tag_valid,
        input  Store_commit_tag, Store_commit_valid, Flush,
        input  Redirect_pc, Redirect_valid, Err_overflow
    );

    modport slave (
        input  Retire_rd_tag, Retire_rd_reg, Retire_data, Retire_pc,
        input  Retire_branch, Retire_branch_taken, Retire_store_ready,
        input  Retire_valid, Tag_take, Store_commit_ready,
        output Arf_wen, Arf_waddr, Arf_wdata, Tag_out, Tag_valid,
        output Store_commit_tag, Store_commit_valid, Flush,
        output Redirect_pc, Redirect_valid, Err_overflow
    );
endinterface

// File: rtl/retire_commit.sv
// Retire consumer: ARF write, free-tag list, committed-store queue, flush.
// Ports: clock, reset (async active-low), rc = retire_commit_if slave.
module retire_commit #(
    parameter int TAG_W        = 5,
    parameter int STQ_DEPTH    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clock,
    input  logic            reset,
    retire_commit_if.slave  rc
);
    localparam int NTAG = 1 << TAG_W;
    localparam int SQ_W = $clog2(STQ_DEPTH);
    localparam int FC_W = $clog2(FLUSH_CYCLES) + 1;

    typedef enum logic {RUN, FLUSH} state_e;

    state_e            state_q, state_d;
    logic [FC_W-1:0]   fc_q, fc_d;
    logic              run;
    logic              accept;
    logic              taken;

    // FSM: state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        fc_d    = fc_q;
        unique case (state_q)
            RUN: begin
                if (taken) begin
                    state_d = FLUSH;
                    fc_d    = FC_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (fc_q == '0) state_d = RUN;
                else            fc_d = fc_q - 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    // FSM: outputs
    always_comb begin
        run    = (state_q == RUN);
        accept = rc.Retire_valid && run;
        taken  = accept && rc.Retire_branch && rc.Retire_branch_taken;
    end

    // Free-tag list
    logic [TAG_W-1:0] fl_q [NTAG];
    logic [TAG_W-1:0] fl_head_q;
    logic [TAG_W:0]   fl_cnt_q;
    logic [TAG_W-1:0] fl_tail;
    logic             fl_full;
    logic             fl_take;
    logic             fl_ret;

    assign fl_tail  = fl_head_q + fl_cnt_q[TAG_W-1:0];
    assign fl_full  = (fl_cnt_q == (TAG_W+1)'(NTAG));
    assign fl_take  = rc.Tag_take && rc.Tag_valid;
    assign fl_ret   = accept && !fl_full;

    assign rc.Tag_valid = (fl_cnt_q != '0) && run;
    assign rc.Tag_out   = fl_q[fl_head_q];

    // A taken branch reclaims every tag, so its own return is absorbed
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NTAG; i++) fl_q[i] <= TAG_W'(i);
            fl_head_q <= '0;
            fl_cnt_q  <= (TAG_W+1)'(NTAG);
        end else if (taken) begin
            for (int i = 0; i < NTAG; i++) fl_q[i] <= TAG_W'(i);
            fl_head_q <= '0;
            fl_cnt_q  <= (TAG_W+1)'(NTAG);
        end else begin
            if (fl_ret) fl_q[fl_tail] <= rc.Retire_rd_tag;
            if (fl_take) fl_head_q <= fl_head_q + 1'b1;
            fl_cnt_q <= fl_cnt_q + {{TAG_W{1'b0}}, fl_ret}
                                 - {{TAG_W{1'b0}}, fl_take};
        end
    end

    // Committed-store queue (survives flush)
    logic [TAG_W-1:0] sq_q [STQ_DEPTH];
    logic [SQ_W-1:0]  sq_head_q;
    logic [SQ_W:0]    sq_cnt_q;
    logic [SQ_W-1:0]  sq_tail;
    logic             sq_full;
    logic             sq_push_req;
    logic             sq_push;
    logic             sq_pop;

    assign sq_tail     = sq_head_q + sq_cnt_q[SQ_W-1:0];
    assign sq_full     = (sq_cnt_q == (SQ_W+1)'(STQ_DEPTH));
    assign sq_push_req = accept && rc.Retire_store_ready;
    assign sq_push     = sq_push_req && !sq_full;
    assign sq_pop      = rc.Store_commit_valid && rc.Store_commit_ready;

    assign rc.Store_commit_valid = (sq_cnt_q != '0);
    assign rc.Store_commit_tag   = sq_q[sq_head_q];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STQ_DEPTH; i++) sq_q[i] <= '0;
            sq_head_q <= '0;
            sq_cnt_q  <= '0;
        end else begin
            if (sq_push) sq_q[sq_tail] <= rc.Retire_rd_tag;
            if (sq_pop) sq_head_q <= sq_head_q + 1'b1;
            sq_cnt_q <= sq_cnt_q + {{SQ_W{1'b0}}, sq_push}
                                 - {{SQ_W{1'b0}}, sq_pop};
        end
    end

    // Registered ARF write, flush/redirect pulses, sticky error
    logic        arf_wen_q;
    logic [4:0]  arf_waddr_q;
    logic [31:0] arf_wdata_q;
    logic        flush_q;
    logic [31:0] rpc_q;
    logic        err_q;
    logic        arf_wen_d;

    assign arf_wen_d = accept && !rc.Retire_branch
                    && !rc.Retire_store_ready
                    && (rc.Retire_rd_reg != 5'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            arf_wen_q   <= 1'b0;
            arf_waddr_q <= '0;
            arf_wdata_q <= '0;
            flush_q     <= 1'b0;
            rpc_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            arf_wen_q <= arf_wen_d;
            if (arf_wen_d) begin
                arf_waddr_q <= rc.Retire_rd_reg;
                arf_wdata_q <= rc.Retire_data;
            end
            flush_q <= taken;
            if (taken) rpc_q <= rc.Retire_pc;
            if ((accept && fl_full && !taken) || (sq_push_req && sq_full))
                err_q <= 1'b1;
        end
    end

    assign rc.Arf_wen        = arf_wen_q;
    assign rc.Arf_waddr      = arf_waddr_q;
    assign rc.Arf_wdata      = arf_wdata_q;
    assign rc.Flush          = flush_q;
    assign rc.Redirect_valid = flush_q;
    assign rc.Redirect_pc    = rpc_q;
    assign rc.Err_overflow   = err_q;
endmodule

// File: tb/tb_retire_commit.sv
// Testbench for retire_commit: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_retire_commit;
    localparam int STQ_DEPTH    = 4;
    localparam int FLUSH_CYCLES = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    retire_commit_if #(.TAG_W(5)) bus ();

    retire_commit #(
        .TAG_W(5), .STQ_DEPTH(STQ_DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .rc(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int          fl[$];
    int          sq[$];
    int          flush_left;
    bit          m_err;
    bit          m_wen;
    int          m_waddr;
    logic [31:0] m_wdata;
    bit          m_flush;
    logic [31:0] m_rpc;

    task automatic model_reset();
        fl.delete();
        for (int i = 0; i < 32; i++) fl.push_back(i);
        sq.delete();
        flush_left = 0;
        m_err = 0; m_wen = 0; m_waddr = 0; m_wdata = '0;
        m_flush = 0; m_rpc = '0;
    endtask

    task automatic idle();
        bus.Retire_valid        = 1'b0;
        bus.Retire_branch       = 1'b0;
        bus.Retire_branch_taken = 1'b0;
        bus.Retire_store_ready  = 1'b0;
        bus.Retire_rd_tag       = '0;
        bus.Retire_rd_reg       = '0;
        bus.Retire_data         = '0;
        bus.Retire_pc           = '0;
        bus.Tag_take            = 1'b0;
        bus.Store_commit_ready  = 1'b0;
    endtask

    task automatic retire(input int tag, input int rd, input logic [31:0] d,
                          input bit br, input bit tk, input bit st,
                          input logic [31:0] pc);
        bus.Retire_valid        = 1'b1;
        bus.Retire_rd_tag       = 5'(tag);
        bus.Retire_rd_reg       = 5'(rd);
        bus.Retire_data         = d;
        bus.Retire_branch       = br;
        bus.Retire_branch_taken = tk;
        bus.Retire_store_ready  = st;
        bus.Retire_pc           = pc;
    endtask

    // Apply the retire rules to the model for the upcoming edge, then clock
    task automatic tick();
        bit run, acc, tk, tv, pop, push;
        int old;
        run = (flush_left == 0);
        tv  = run && (fl.size() > 0);
        acc = bus.Retire_valid && run;
        tk  = acc && bus.Retire_branch && bus.Retire_branch_taken;
        m_wen = acc && !bus.Retire_branch && !bus.Retire_store_ready
                && (bus.Retire_rd_reg != 0);
        if (m_wen) begin
            m_waddr = int'(bus.Retire_rd_reg);
            m_wdata = bus.Retire_data;
        end
        m_flush = tk;
        if (tk) m_rpc = bus.Retire_pc;
        old  = sq.size();
        pop  = (old > 0) && bus.Store_commit_ready;
        push = acc && bus.Retire_store_ready;
        if (pop) void'(sq.pop_front());
        if (push) begin
            if (old == STQ_DEPTH) m_err = 1;
            else sq.push_back(int'(bus.Retire_rd_tag));
        end
        if (tk) begin
            fl.delete();
            for (int i = 0; i < 32; i++) fl.push_back(i);
            flush_left = FLUSH_CYCLES;
        end else begin
            if (flush_left > 0) flush_left--;
            old = fl.size();
            if (bus.Tag_take && tv) void'(fl.pop_front());
            if (acc) begin
                if (old == 32) m_err = 1;
                else fl.push_back(int'(bus.Retire_rd_tag));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #7;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #3;
        checks++;
        if (bus.Arf_wen !== 1'b0 || bus.Arf_waddr !== 5'd0
            || bus.Arf_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_arf got %b/%0d/%h exp 0/0/0",
                     bus.Arf_wen, bus.Arf_waddr, bus.Arf_wdata);
        end
        checks++;
        if (bus.Flush !== 1'b0 || bus.Redirect_valid !== 1'b0
            || bus.Redirect_pc !== 32'd0 || bus.Err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush got %b/%b/%h/%b exp 0/0/0/0",
                     bus.Flush, bus.Redirect_valid, bus.Redirect_pc,
                     bus.Err_overflow);
        end
        checks++;
        if (bus.Store_commit_valid !== 1'b0
            || bus.Store_commit_tag !== 5'd0) begin
            errors++;
            $display("FAIL reset_stq got %b/%0d exp 0/0",
                     bus.Store_commit_valid, bus.Store_commit_tag);
        end
        do_reset();
        checks++;
        if (bus.Tag_valid !== 1'b1 || bus.Tag_out !== 5'd0) begin
            errors++;
            $display("FAIL reset_tag got %b/%0d exp 1/0",
                     bus.Tag_valid, bus.Tag_out);
        end
    endtask

    task automatic test_tag_take();
        bus.Tag_take = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.Tag_out !== 5'(i) || bus.Tag_valid !== 1'b1) begin
                errors++;
                $display("FAIL take_seq got %0d/%b exp %0d/1",
                         bus.Tag_out, bus.Tag_valid, i);
            end
            tick();
        end
        bus.Tag_take = 1'b0;
        checks++;
        if (bus.Tag_out !== 5'd3) begin
            errors++;
            $display("FAIL take_fourth got %0d exp 3", bus.Tag_out);
        end
    endtask

    task automatic test_arf_write();
        retire(1, 7, 32'hDEADBEEF, 0, 0, 0, 32'd0);
        tick();
        idle();
        checks++;
        if (bus.Arf_wen !== 1'b1 || bus.Arf_waddr !== 5'd7
            || bus.Arf_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL arf_write got %b/%0d/%h exp 1/7/deadbeef",
                     bus.Arf_wen, bus.Arf_waddr, bus.Arf_wdata);
        end
        bus.Tag_take = 1'b1;
        for (int i = 3; i < 32; i++) begin
            checks++;
            if (bus.Tag_out !== 5'(i)) begin
                errors++;
                $display("FAIL drain_seq got %0d exp %0d", bus.Tag_out, i);
            end
            tick();
        end
        bus.Tag_take = 1'b0;
        checks++;
        if (bus.Tag_out !== 5'd1 || bus.Tag_valid !== 1'b1) begin
            errors++;
            $display("FAIL returned_tag got %0d/%b exp 1/1",
                     bus.Tag_out, bus.Tag_valid);
        end
    endtask

    task automatic test_rd0_branch();
        retire(2, 0, 32'h12345678, 0, 0, 0, 32'd0);
        tick();
        idle();
        checks++;
        if (bus.Arf_wen !== 1'b0) begin
            errors++;
            $display("FAIL rd0_wen got %b exp 0", bus.Arf_wen);
        end
        bus.Tag_take = 1'b1;
        tick();
        bus.Tag_take = 1'b0;
        checks++;
        if (bus.Tag_out !== 5'd2 || bus.Tag_valid !== 1'b1) begin
            errors++;
            $display("FAIL rd0_tag_ret got %0d/%b exp 2/1",
                     bus.Tag_out, bus.Tag_valid);
        end
        retire(3, 9, 32'h0BAD0BAD, 1, 0, 0, 32'h00001000);
        tick();
        idle();
        checks++;
        if (bus.Arf_wen !== 1'b0 || bus.Flush !== 1'b0
            || bus.Redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL nt_branch got wen %b flush %b rv %b exp 0/0/0",
                     bus.Arf_wen, bus.Flush, bus.Redirect_valid);
        end
    endtask

    task automatic test_store_overflow();
        for (int t = 4; t <= 8; t++) begin
            retire(t, 5, 32'd0, 0, 0, 1, 32'd0);
            tick();
        end
        idle();
        checks++;
        if (bus.Err_overflow !== 1'b1 || bus.Arf_wen !== 1'b0) begin
            errors++;
            $display("FAIL stq_ovf got err %b wen %b exp 1/0",
                     bus.Err_overflow, bus.Arf_wen);
        end
        bus.Store_commit_ready = 1'b1;
        for (int t = 4; t <= 7; t++) begin
            checks++;
            if (bus.Store_commit_valid !== 1'b1
                || bus.Store_commit_tag !== 5'(t)) begin
                errors++;
                $display("FAIL stq_pop got %b/%0d exp 1/%0d",
                         bus.Store_commit_valid, bus.Store_commit_tag, t);
            end
            tick();
        end
        bus.Store_commit_ready = 1'b0;
        checks++;
        if (bus.Store_commit_valid !== 1'b0) begin
            errors++;
            $display("FAIL stq_empty got %b exp 0", bus.Store_commit_valid);
        end
    endtask

    task automatic test_taken_flush();
        retire(10, 0, 32'd0, 0, 0, 1, 32'd0);
        tick();
        retire(11, 0, 32'd0, 0, 0, 1, 32'd0);
        tick();
        retire(12, 3, 32'd0, 1, 1, 0, 32'h00400040);
        bus.Tag_take = 1'b1;
        tick();
        checks++;
        if (bus.Flush !== 1'b1 || bus.Redirect_valid !== 1'b1
            || bus.Redirect_pc !== 32'h00400040) begin
            errors++;
            $display("FAIL flush_pulse got %b/%b/%h exp 1/1/00400040",
                     bus.Flush, bus.Redirect_valid, bus.Redirect_pc);
        end
        checks++;
        if (bus.Tag_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_tv1 got %b exp 0", bus.Tag_valid);
        end
        retire(13, 4, 32'd0, 1, 1, 1, 32'h00000800);
        tick();
        checks++;
        if (bus.Flush !== 1'b0 || bus.Redirect_valid !== 1'b0
            || bus.Tag_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_c2 got %b/%b/%b exp 0/0/0",
                     bus.Flush, bus.Redirect_valid, bus.Tag_valid);
        end
        retire(14, 9, 32'hCAFEF00D, 0, 0, 0, 32'd0);
        tick();
        idle();
        checks++;
        if (bus.Arf_wen !== 1'b0 || bus.Flush !== 1'b0) begin
            errors++;
            $display("FAIL flush_ignored got wen %b flush %b exp 0/0",
                     bus.Arf_wen, bus.Flush);
        end
        checks++;
        if (bus.Tag_valid !== 1'b1 || bus.Tag_out !== 5'd0) begin
            errors++;
            $display("FAIL flush_tags got %b/%0d exp 1/0",
                     bus.Tag_valid, bus.Tag_out);
        end
        checks++;
        if (bus.Store_commit_valid !== 1'b1
            || bus.Store_commit_tag !== 5'd10) begin
            errors++;
            $display("FAIL flush_stq got %b/%0d exp 1/10",
                     bus.Store_commit_valid, bus.Store_commit_tag);
        end
    endtask

    task automatic test_reset_mid_flush();
        retire(15, 0, 32'd0, 1, 1, 0, 32'h00008000);
        tick();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.Flush !== 1'b0 || bus.Redirect_valid !== 1'b0
            || bus.Redirect_pc !== 32'd0 || bus.Err_overflow !== 1'b0
            || bus.Arf_wen !== 1'b0) begin
            errors++;
            $display("FAIL midrst_out got %b/%b/%h/%b/%b exp 0/0/0/0/0",
                     bus.Flush, bus.Redirect_valid, bus.Redirect_pc,
                     bus.Err_overflow, bus.Arf_wen);
        end
        checks++;
        if (bus.Store_commit_valid !== 1'b0
            || bus.Store_commit_tag !== 5'd0) begin
            errors++;
            $display("FAIL midrst_stq got %b/%0d exp 0/0",
                     bus.Store_commit_valid, bus.Store_commit_tag);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.Tag_out !== 5'd0 || bus.Tag_valid !== 1'b1
            || bus.Store_commit_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_rel got %0d/%b/%b exp 0/1/0",
                     bus.Tag_out, bus.Tag_valid, bus.Store_commit_valid);
        end
    endtask

    task automatic test_random();
        bit br, st;
        int rd;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            idle();
            if ($urandom_range(0, 1) == 1) begin
                br = ($urandom_range(0, 9) < 2);
                st = !br && ($urandom_range(0, 3) == 0);
                rd = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31);
                retire($urandom_range(0, 31), rd, $urandom, br,
                       br && ($urandom_range(0, 2) == 0), st, $urandom);
            end
            bus.Tag_take           = ($urandom_range(0, 9) < 7);
            bus.Store_commit_ready = ($urandom_range(0, 1) == 1);
            tick();
            checks++;
            if (bus.Arf_wen !== m_wen
                || (m_wen && (bus.Arf_waddr !== 5'(m_waddr)
                              || bus.Arf_wdata !== m_wdata))) begin
                errors++;
                $display("FAIL rnd_arf got %b/%0d/%h exp %b/%0d/%h",
                         bus.Arf_wen, bus.Arf_waddr, bus.Arf_wdata,
                         m_wen, m_waddr, m_wdata);
            end
            checks++;
            if (bus.Flush !== m_flush || bus.Redirect_valid !== m_flush
                || (m_flush && bus.Redirect_pc !== m_rpc)) begin
                errors++;
                $display("FAIL rnd_flush got %b/%b/%h exp %b/%b/%h",
                         bus.Flush, bus.Redirect_valid, bus.Redirect_pc,
                         m_flush, m_flush, m_rpc);
            end
            checks++;
            if (bus.Err_overflow !== m_err) begin
                errors++;
                $display("FAIL rnd_err got %b exp %b", bus.Err_overflow, m_err);
            end
            checks++;
            if (bus.Tag_valid !== (flush_left == 0 && fl.size() > 0)
                || (bus.Tag_valid && bus.Tag_out !== 5'(fl[0]))) begin
                errors++;
                $display("FAIL rnd_tag got %b/%0d exp %b/%0d",
                         bus.Tag_valid, bus.Tag_out,
                         (flush_left == 0 && fl.size() > 0),
                         (fl.size() > 0) ? fl[0] : -1);
            end
            checks++;
            if (bus.Store_commit_valid !== (sq.size() > 0)
                || (sq.size() > 0 && bus.Store_commit_tag !== 5'(sq[0]))) begin
                errors++;
                $display("FAIL rnd_stq got %b/%0d exp %b/%0d",
                         bus.Store_commit_valid, bus.Store_commit_tag,
                         (sq.size() > 0), (sq.size() > 0) ? sq[0] : -1);
            end
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        test_reset();
        test_tag_take();
        test_arf_write();
        test_rd0_branch();
        test_store_overflow();
        test_taken_flush();
        test_reset_mid_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/retire_commit.md
Name: retire_commit

Overview:
Consumer end of the ROB retire bus. Each cycle it accepts at most one retired instruction and does four things:
- writes the architectural register file;
- returns the retired tag to a 32-entry free-tag list, which supplies new Rd tags to dispatch;
- queues committed stores for the store buffer;
- on a taken (mispredicted) branch, issues the pipeline flush and the fetch redirect.

Parameters:
TAG_W, 5, tag width; free list holds 2**TAG_W tags
STQ_DEPTH, 4, committed-store queue depth (power of 2)
FLUSH_CYCLES, 2, cycles spent in FLUSH state

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-low reset
Retire_rd_tag  in  5  tag of retiring instruction
Retire_rd_reg  in  5  architectural destination register
Retire_data  in  32  result value
Retire_pc  in  32  branch target (meaningful only on taken branch)
Retire_branch  in  1  retiring instruction is a branch
Retire_branch_taken  in  1  branch must be taken (misprediction)
Retire_store_ready  in  1  retiring instruction is a store
Retire_valid  in  1  retire bus valid
Arf_wen  out  1  architectural RF write enable
Arf_waddr  out  5  RF write address
Arf_wdata  out  32  RF write data
Tag_out  out  5  next free tag for dispatch
Tag_valid  out  1  Tag_out usable
Tag_take  in  1  dispatch consumes Tag_out this cycle
Store_commit_tag  out  5  tag of oldest committed store
Store_commit_valid  out  1  store queue not empty
Store_commit_ready  in  1  store buffer accepts head
Flush  out  1  one-cycle flush pulse to ROB/RS/order queue
Redirect_pc  out  32  fetch redirect target
Redirect_valid  out  1  one-cycle redirect pulse
Err_overflow  out  1  sticky: tag-list or store-queue overflow

Behaviour:
- Reset (reset=0, asynchronous):
  - Free list contains tags 0..31 in ascending order, head=0, count=32.
  - Store queue empty.
  - FSM = RUN.
  - Outputs: Arf_wen=0, Arf_waddr=0, Arf_wdata=0, Flush=0, Redirect_pc=0, Redirect_valid=0, Err_overflow=0, Store_commit_valid=0, Store_commit_tag=0.
  - Tag_out=0, Tag_valid=1 from the first cycle after reset deasserts.
- FSM states:
  - RUN: FSM leaves RUN when an accepted retire has Retire_branch=1 and Retire_branch_taken=1.
  - FLUSH: counter runs FLUSH_CYCLES-1 down to 0; FSM returns to RUN when the counter reaches 0.
- Retire acceptance: a retire is accepted only when Retire_valid=1 and FSM=RUN. In FLUSH, the retire bus is ignored entirely.
- On an accepted retire, with outputs registered one cycle later:
  - Arf write: Arf_wen=1 only if not branch, not store, and Retire_rd_reg!=0. Then Arf_waddr=Retire_rd_reg, Arf_wdata=Retire_data. A write to $0 is suppressed.
  - Tag return: Retire_rd_tag is always pushed to the free-list tail, for every instruction type.
  - Store: {Retire_rd_tag} is pushed to the store queue.
  - Taken branch: Flush=1 and Redirect_valid=1 for one cycle, Redirect_pc=Retire_pc, FSM→FLUSH. Not-taken branch: tag return only.
- Free list:
  - Tag_valid = (count>0) && FSM==RUN.
  - Tag_take while Tag_valid=0 is ignored.
  - Take and return in the same cycle: both happen, count unchanged. When count==0, the returned tag becomes visible next cycle.
  - Return when count==32: tag dropped, Err_overflow set.
- On entry to FLUSH (same edge as the Flush pulse), the free list is reinitialised to all 32 tags in ascending order, head=0, count=32. All in-flight tags are reclaimed, and any same-cycle Tag_take is ignored.
- Store queue:
  - Pop when Store_commit_valid && Store_commit_ready.
  - Push and pop in the same cycle are both honoured.
  - Push when full: entry dropped, Err_overflow set.
  - Store queue is NOT cleared by flush, because its entries are architecturally committed.
  - Store_commit_tag = head entry.
- Only one flush can be in progress; retires arriving during FLUSH, including taken branches, produce no effect.
- Pointers wrap modulo depth. count widths are TAG_W+1 and log2(STQ_DEPTH)+1.
- Err_overflow is cleared only by reset.

Test Plan:
- Reset, then take 3 tags with back-to-back Tag_take → Tag_out=0,1,2; fourth cycle Tag_out=3; count=29.
- Retire tag 1, rd_reg 7, data 0xDEADBEEF, valid → next cycle Arf_wen=1, waddr=7, wdata=0xDEADBEEF. Tag 1 reaches Tag_out after tags 3..31 are taken.
- Retire with rd_reg=0 → Arf_wen stays 0 and the tag is still returned. Retire of a not-taken branch → no Arf write, no Flush.
- Retire 5 stores (tags 4..8) with Store_commit_ready=0 → queue holds 4..7, Err_overflow=1. Raise ready → Store_commit_tag sequence 4,5,6,7, then Store_commit_valid=0.
- Retire taken branch with Retire_pc=0x00400040 → one-cycle Flush=1, Redirect_valid=1, Redirect_pc=0x00400040. Tag_valid=0 for 2 cycles, retires in those cycles are ignored, and the store queue is unchanged. Afterwards Tag_out=0, count=32.
- Assert reset mid-FLUSH with store queue non-empty → all outputs return to reset values immediately; after release, Tag_out=0, Tag_valid=1, Store_commit_valid=0.
